// File: rtl/axi_arbiter_2to1_if.sv
// AXI4 channel bundle (AR/R/AW/W/B) shared by the two upstream masters and the
// downstream slave port of the 2:1 arbiter. Widths are set per instance.
interface axi_channel #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ID_W   = 4
);
  logic                  ar_valid;
  logic                  ar_ready;
  logic [ADDR_W-1:0]     ar_addr;
  logic [7:0]            ar_len;
  logic [ID_W-1:0]       ar_id;

  logic                  r_valid;
  logic                  r_ready;
  logic [DATA_W-1:0]     r_data;
  logic [ID_W-1:0]       r_id;
  logic [1:0]            r_resp;
  logic                  r_last;

  logic                  aw_valid;
  logic                  aw_ready;
  logic [ADDR_W-1:0]     aw_addr;
  logic [7:0]            aw_len;
  logic [ID_W-1:0]       aw_id;

  logic                  w_valid;
  logic                  w_ready;
  logic [DATA_W-1:0]     w_data;
  logic [DATA_W/8-1:0]   w_strb;
  logic                  w_last;

  logic                  b_valid;
  logic                  b_ready;
  logic [ID_W-1:0]       b_id;
  logic [1:0]            b_resp;

  // Requester side of the bus.
  modport master (
    output ar_valid, ar_addr, ar_len, ar_id,
    input  ar_ready,
    input  r_valid, r_data, r_id, r_resp, r_last,
    output r_ready,
    output aw_valid, aw_addr, aw_len, aw_id,
    input  aw_ready,
    output w_valid, w_data, w_strb, w_last,
    input  w_ready,
    input  b_valid, b_id, b_resp,
    output b_ready
  );

  // Responder side of the bus.
  modport slave (
    input  ar_valid, ar_addr, ar_len, ar_id,
    output ar_ready,
    output r_valid, r_data, r_id, r_resp, r_last,
    input  r_ready,
    input  aw_valid, aw_addr, aw_len, aw_id,
    output aw_ready,
    input  w_valid, w_data, w_strb, w_last,
    output w_ready,
    output b_valid, b_id, b_resp,
    input  b_ready
  );
endinterface

// File: rtl/axi_arbiter_2to1.sv
// 2:1 AXI4 arbiter. Read (AR/R) and write (AW/W/B) paths each own a small FSM
// and a registered grant; one transaction per path is in flight at a time, so
// IDs pass through untouched. Outputs are a pure mux selected by state+grant.
module axi_arbiter_2to1 #(
  parameter int unsigned ROUND_ROBIN = 1
) (
  input  logic       clk,
  input  logic       rstn,
  axi_channel.slave  master0,
  axi_channel.slave  master1,
  axi_channel.master slave
);

  localparam bit RrEn = (ROUND_ROBIN != 0);

  typedef enum logic [1:0] {StRIdle, StRAddr, StRData} rd_state_e;
  typedef enum logic [1:0] {StWIdle, StWBusy, StWResp} wr_state_e;

  rd_state_e r_rd_state;
  wr_state_e r_wr_state;
  logic      r_gr;            // read grant: 0 = master0, 1 = master1
  logic      r_gw;            // write grant
  logic      r_rr_last_rd;
  logic      r_rr_last_wr;
  logic      r_aw_done;
  logic      r_w_done;

  logic w_gr_next;
  logic w_gw_next;
  logic w_rd_addr;
  logic w_rd_data;
  logic w_aw_fwd;
  logic w_w_fwd;
  logic w_b_fwd;
  logic w_ar_hs;
  logic w_r_last_hs;
  logic w_aw_hs;
  logic w_w_last_hs;
  logic w_b_hs;

  // master1 wins if it is alone, or if both request and it is its turn.
  assign w_gr_next = master1.ar_valid & (~master0.ar_valid | (RrEn & ~r_rr_last_rd));
  assign w_gw_next = master1.aw_valid & (~master0.aw_valid | (RrEn & ~r_rr_last_wr));

  assign w_rd_addr = (r_rd_state == StRAddr);
  assign w_rd_data = (r_rd_state == StRData);
  assign w_aw_fwd  = (r_wr_state == StWBusy) & ~r_aw_done;
  assign w_w_fwd   = (r_wr_state == StWBusy) & ~r_w_done;
  assign w_b_fwd   = (r_wr_state == StWResp);

  assign w_ar_hs     = slave.ar_valid & slave.ar_ready;
  assign w_r_last_hs = slave.r_valid & slave.r_ready & slave.r_last;
  assign w_aw_hs     = slave.aw_valid & slave.aw_ready;
  assign w_w_last_hs = slave.w_valid & slave.w_ready & slave.w_last;
  assign w_b_hs      = slave.b_valid & slave.b_ready;

  // AR request mux towards the slave.
  assign slave.ar_valid = w_rd_addr & (r_gr ? master1.ar_valid : master0.ar_valid);
  assign slave.ar_addr  = r_gr ? master1.ar_addr : master0.ar_addr;
  assign slave.ar_len   = r_gr ? master1.ar_len  : master0.ar_len;
  assign slave.ar_id    = r_gr ? master1.ar_id   : master0.ar_id;
  assign master0.ar_ready = w_rd_addr & ~r_gr & slave.ar_ready;
  assign master1.ar_ready = w_rd_addr &  r_gr & slave.ar_ready;

  // R response demux; payload is broadcast, only valid is steered.
  assign master0.r_valid = w_rd_data & ~r_gr & slave.r_valid;
  assign master1.r_valid = w_rd_data &  r_gr & slave.r_valid;
  assign master0.r_data  = slave.r_data;
  assign master1.r_data  = slave.r_data;
  assign master0.r_id    = slave.r_id;
  assign master1.r_id    = slave.r_id;
  assign master0.r_resp  = slave.r_resp;
  assign master1.r_resp  = slave.r_resp;
  assign master0.r_last  = slave.r_last;
  assign master1.r_last  = slave.r_last;
  assign slave.r_ready   = w_rd_data & (r_gw_sel_rd(r_gr));

  // AW request mux towards the slave.
  assign slave.aw_valid = w_aw_fwd & (r_gw ? master1.aw_valid : master0.aw_valid);
  assign slave.aw_addr  = r_gw ? master1.aw_addr : master0.aw_addr;
  assign slave.aw_len   = r_gw ? master1.aw_len  : master0.aw_len;
  assign slave.aw_id    = r_gw ? master1.aw_id   : master0.aw_id;
  assign master0.aw_ready = w_aw_fwd & ~r_gw & slave.aw_ready;
  assign master1.aw_ready = w_aw_fwd &  r_gw & slave.aw_ready;

  // W data mux towards the slave.
  assign slave.w_valid = w_w_fwd & (r_gw ? master1.w_valid : master0.w_valid);
  assign slave.w_data  = r_gw ? master1.w_data : master0.w_data;
  assign slave.w_strb  = r_gw ? master1.w_strb : master0.w_strb;
  assign slave.w_last  = r_gw ? master1.w_last : master0.w_last;
  assign master0.w_ready = w_w_fwd & ~r_gw & slave.w_ready;
  assign master1.w_ready = w_w_fwd &  r_gw & slave.w_ready;

  // B response demux.
  assign master0.b_valid = w_b_fwd & ~r_gw & slave.b_valid;
  assign master1.b_valid = w_b_fwd &  r_gw & slave.b_valid;
  assign master0.b_id    = slave.b_id;
  assign master1.b_id    = slave.b_id;
  assign master0.b_resp  = slave.b_resp;
  assign master1.b_resp  = slave.b_resp;
  assign slave.b_ready   = w_b_fwd & (r_gw ? master1.b_ready : master0.b_ready);

  function automatic logic r_gw_sel_rd(input logic sel);
    return sel ? master1.r_ready : master0.r_ready;
  endfunction

  // Read path FSM: arbitrate in idle, forward AR, then R until the last beat.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rd_state   <= StRIdle;
      r_gr         <= 1'b0;
      r_rr_last_rd <= 1'b1;
    end else begin
      unique case (r_rd_state)
        StRIdle: begin
          if (master0.ar_valid | master1.ar_valid) begin
            r_gr       <= w_gr_next;
            r_rd_state <= StRAddr;
          end
        end
        StRAddr: if (w_ar_hs) r_rd_state <= StRData;
        StRData: begin
          if (w_r_last_hs) begin
            r_rr_last_rd <= r_gr;
            r_rd_state   <= StRIdle;
          end
        end
        default: r_rd_state <= StRIdle;
      endcase
    end
  end

  // Write path FSM: AW and W complete independently, then wait for B.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_state   <= StWIdle;
      r_gw         <= 1'b0;
      r_rr_last_wr <= 1'b1;
      r_aw_done    <= 1'b0;
      r_w_done     <= 1'b0;
    end else begin
      unique case (r_wr_state)
        StWIdle: begin
          if (master0.aw_valid | master1.aw_valid) begin
            r_gw       <= w_gw_next;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
            r_wr_state <= StWBusy;
          end
        end
        StWBusy: begin
          if (w_aw_hs)     r_aw_done <= 1'b1;
          if (w_w_last_hs) r_w_done  <= 1'b1;
          // Leave as soon as the second of AW / last-W completes.
          if ((r_aw_done | w_aw_hs) & (r_w_done | w_w_last_hs)) r_wr_state <= StWResp;
        end
        StWResp: begin
          if (w_b_hs) begin
            r_rr_last_wr <= r_gw;
            r_wr_state   <= StWIdle;
          end
        end
        default: r_wr_state <= StWIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_arbiter_2to1.sv
// Scoreboard bench for axi_arbiter_2to1: expected AR/R/AW/W/B items are queued
// when stimulus is issued and checked by a monitor on every handshake.
module tb_axi_arbiter_2to1;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  axi_channel m0_if ();
  axi_channel m1_if ();
  axi_channel s_if ();

  axi_arbiter_2to1 #(.ROUND_ROBIN(1)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .master0 (m0_if),
    .master1 (m1_if),
    .slave   (s_if)
  );

  // Master-side drive variables, indexed by master number.
  logic        m_ar_valid [2];
  logic [31:0] m_ar_addr  [2];
  logic [7:0]  m_ar_len   [2];
  logic [3:0]  m_ar_id    [2];
  logic        m_aw_valid [2];
  logic [31:0] m_aw_addr  [2];
  logic [7:0]  m_aw_len   [2];
  logic [3:0]  m_aw_id    [2];
  logic        m_w_valid  [2];
  logic [31:0] m_w_data   [2];
  logic        m_w_last   [2];
  logic        m_r_ready  [2];
  logic        m_b_ready  [2];

  assign m0_if.ar_valid = m_ar_valid[0];
  assign m0_if.ar_addr  = m_ar_addr[0];
  assign m0_if.ar_len   = m_ar_len[0];
  assign m0_if.ar_id    = m_ar_id[0];
  assign m0_if.aw_valid = m_aw_valid[0];
  assign m0_if.aw_addr  = m_aw_addr[0];
  assign m0_if.aw_len   = m_aw_len[0];
  assign m0_if.aw_id    = m_aw_id[0];
  assign m0_if.w_valid  = m_w_valid[0];
  assign m0_if.w_data   = m_w_data[0];
  assign m0_if.w_strb   = 4'hF;
  assign m0_if.w_last   = m_w_last[0];
  assign m0_if.r_ready  = m_r_ready[0];
  assign m0_if.b_ready  = m_b_ready[0];
  assign m1_if.ar_valid = m_ar_valid[1];
  assign m1_if.ar_addr  = m_ar_addr[1];
  assign m1_if.ar_len   = m_ar_len[1];
  assign m1_if.ar_id    = m_ar_id[1];
  assign m1_if.aw_valid = m_aw_valid[1];
  assign m1_if.aw_addr  = m_aw_addr[1];
  assign m1_if.aw_len   = m_aw_len[1];
  assign m1_if.aw_id    = m_aw_id[1];
  assign m1_if.w_valid  = m_w_valid[1];
  assign m1_if.w_data   = m_w_data[1];
  assign m1_if.w_strb   = 4'hF;
  assign m1_if.w_last   = m_w_last[1];
  assign m1_if.r_ready  = m_r_ready[1];
  assign m1_if.b_ready  = m_b_ready[1];

  // Slave-side drive variables.
  logic        s_ar_ready, s_r_valid, s_r_last, s_aw_ready, s_w_ready, s_b_valid;
  logic [31:0] s_r_data;
  logic [3:0]  s_r_id, s_b_id;
  assign s_if.ar_ready = s_ar_ready;
  assign s_if.r_valid  = s_r_valid;
  assign s_if.r_data   = s_r_data;
  assign s_if.r_id     = s_r_id;
  assign s_if.r_resp   = 2'b00;
  assign s_if.r_last   = s_r_last;
  assign s_if.aw_ready = s_aw_ready;
  assign s_if.w_ready  = s_w_ready;
  assign s_if.b_valid  = s_b_valid;
  assign s_if.b_id     = s_b_id;
  assign s_if.b_resp   = 2'b00;

  typedef struct packed {logic [31:0] addr; logic [7:0] len; logic [3:0] id;} a_t;
  typedef struct packed {logic [3:0] id; logic [31:0] data; logic last;} r_t;
  typedef struct packed {logic [31:0] data; logic last;} w_t;
  typedef struct packed {logic [3:0] id; logic [1:0] resp;} b_t;

  a_t exp_ar [$];
  a_t exp_aw [$];
  r_t exp_r0 [$];
  r_t exp_r1 [$];
  w_t exp_w  [$];
  b_t exp_b0 [$];
  b_t exp_b1 [$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int aw_cnt  = 0;
  int aw_hs_cyc  = 0;
  int w_last_cyc = 0;
  int aw_hold_cfg = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic flag(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got timeout/unexpected event, expected normal completion", name);
  endtask

  function automatic logic [14:0] drv_outs();
    return {s_if.ar_valid, s_if.aw_valid, s_if.w_valid, s_if.r_ready, s_if.b_ready,
            m0_if.ar_ready, m0_if.aw_ready, m0_if.w_ready, m0_if.r_valid, m0_if.b_valid,
            m1_if.ar_ready, m1_if.aw_ready, m1_if.w_ready, m1_if.r_valid, m1_if.b_valid};
  endfunction

  function automatic logic get_ready(input int m, input int ch);
    case (ch)
      0:       return (m == 0) ? m0_if.ar_ready : m1_if.ar_ready;
      1:       return (m == 0) ? m0_if.aw_ready : m1_if.aw_ready;
      default: return (m == 0) ? m0_if.w_ready  : m1_if.w_ready;
    endcase
  endfunction

  // Waits at negedges for the ready of channel ch; returns at posedge+1.
  task automatic wait_ready(input int m, input int ch, input string name);
    logic ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (get_ready(m, ch)) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) flag(name);
    @(posedge clk);
    #1;
  endtask

  task automatic issue_ar(input int m, input logic [31:0] addr, input logic [7:0] len,
                          input logic [3:0] id);
    m_ar_valid[m] = 1'b1;
    m_ar_addr[m]  = addr;
    m_ar_len[m]   = len;
    m_ar_id[m]    = id;
    wait_ready(m, 0, "ar_ready_timeout");
    m_ar_valid[m] = 1'b0;
  endtask

  task automatic issue_wr(input int m, input logic [31:0] addr, input logic [7:0] len,
                          input logic [3:0] id, input logic [31:0] dbase);
    fork
      begin
        m_aw_valid[m] = 1'b1;
        m_aw_addr[m]  = addr;
        m_aw_len[m]   = len;
        m_aw_id[m]    = id;
        wait_ready(m, 1, "aw_ready_timeout");
        m_aw_valid[m] = 1'b0;
      end
      begin
        for (int b = 0; b <= int'(len); b++) begin
          m_w_valid[m] = 1'b1;
          m_w_data[m]  = dbase + 32'(b);
          m_w_last[m]  = (b == int'(len));
          wait_ready(m, 2, "w_ready_timeout");
        end
        m_w_valid[m] = 1'b0;
        m_w_last[m]  = 1'b0;
      end
    join
  endtask

  // Expected: slave returns data = addr + beat index, with the request ID.
  task automatic push_read(input int m, input logic [31:0] addr, input logic [7:0] len,
                           input logic [3:0] id);
    r_t r;
    exp_ar.push_back('{addr: addr, len: len, id: id});
    for (int i = 0; i <= int'(len); i++) begin
      r = '{id: id, data: addr + 32'(i), last: (i == int'(len))};
      if (m == 0) exp_r0.push_back(r);
      else        exp_r1.push_back(r);
    end
  endtask

  task automatic push_write(input int m, input logic [31:0] addr, input logic [7:0] len,
                            input logic [3:0] id, input logic [31:0] dbase);
    exp_aw.push_back('{addr: addr, len: len, id: id});
    for (int i = 0; i <= int'(len); i++)
      exp_w.push_back('{data: dbase + 32'(i), last: (i == int'(len))});
    if (m == 0) exp_b0.push_back('{id: id, resp: 2'b00});
    else        exp_b1.push_back('{id: id, resp: 2'b00});
  endtask

  function automatic bit all_empty();
    return exp_ar.size() == 0 && exp_aw.size() == 0 && exp_r0.size() == 0 &&
           exp_r1.size() == 0 && exp_w.size() == 0 && exp_b0.size() == 0 &&
           exp_b1.size() == 0;
  endfunction

  task automatic wait_drain(input string name);
    for (int i = 0; i < 300; i++) begin
      if (all_empty()) break;
      @(posedge clk);
    end
    if (!all_empty()) flag(name);
    #1;
  endtask

  task automatic clear_queues();
    exp_ar.delete(); exp_aw.delete(); exp_r0.delete(); exp_r1.delete();
    exp_w.delete();  exp_b0.delete(); exp_b1.delete();
  endtask

  task automatic clear_masters();
    for (int m = 0; m < 2; m++) begin
      m_ar_valid[m] = 1'b0; m_ar_addr[m] = '0; m_ar_len[m] = '0; m_ar_id[m] = '0;
      m_aw_valid[m] = 1'b0; m_aw_addr[m] = '0; m_aw_len[m] = '0; m_aw_id[m] = '0;
      m_w_valid[m]  = 1'b0; m_w_data[m]  = '0; m_w_last[m] = 1'b0;
      m_r_ready[m]  = 1'b1; m_b_ready[m] = 1'b1;
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    clear_masters();
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    clear_queues();
  endtask

  // Cycle counter.
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Slave model: samples handshakes at negedge, updates its outputs after the edge.
  initial begin : slave_model
    logic        ar_hs, r_hs, aw_seen, aw_hs, w_last_hs, b_hs;
    logic [31:0] ar_addr_s;
    logic [7:0]  ar_len_s;
    logic [3:0]  ar_id_s, aw_id_s;
    logic        rd_busy = 1'b0, aw_got = 1'b0, w_got = 1'b0;
    logic [31:0] rd_addr = '0;
    logic [7:0]  rd_len = '0, rd_beat = '0;
    logic [3:0]  rd_id = '0, wr_id = '0;
    int          aw_seen_cnt = 0;
    forever begin
      @(negedge clk);
      ar_hs     = s_if.ar_valid && s_if.ar_ready;
      ar_addr_s = s_if.ar_addr;
      ar_len_s  = s_if.ar_len;
      ar_id_s   = s_if.ar_id;
      r_hs      = s_if.r_valid && s_if.r_ready;
      aw_seen   = s_if.aw_valid;
      aw_hs     = s_if.aw_valid && s_if.aw_ready;
      aw_id_s   = s_if.aw_id;
      w_last_hs = s_if.w_valid && s_if.w_ready && s_if.w_last;
      b_hs      = s_if.b_valid && s_if.b_ready;
      @(posedge clk);
      #1;
      if (!rstn) begin
        rd_busy = 1'b0; aw_got = 1'b0; w_got = 1'b0; aw_seen_cnt = 0;
      end else begin
        if (r_hs) begin
          if (rd_beat == rd_len) rd_busy = 1'b0;
          else rd_beat = rd_beat + 8'd1;
        end
        if (ar_hs) begin
          rd_busy = 1'b1; rd_addr = ar_addr_s; rd_len = ar_len_s; rd_id = ar_id_s;
          rd_beat = '0;
        end
        if (aw_seen && !aw_got) aw_seen_cnt++;
        if (aw_hs) begin
          aw_got = 1'b1;
          wr_id  = aw_id_s;
        end
        if (w_last_hs) w_got = 1'b1;
        if (b_hs) begin
          aw_got = 1'b0; w_got = 1'b0; aw_seen_cnt = 0;
        end
      end
      s_ar_ready = rstn && !rd_busy;
      s_r_valid  = rd_busy;
      s_r_data   = rd_addr + {24'd0, rd_beat};
      s_r_id     = rd_id;
      s_r_last   = (rd_beat == rd_len);
      s_aw_ready = rstn && !aw_got && (aw_seen_cnt >= aw_hold_cfg);
      s_w_ready  = rstn && !w_got;
      s_b_valid  = aw_got && w_got;
      s_b_id     = wr_id;
    end
  end

  // Monitor: every handshake pops and checks the matching expected item.
  initial forever begin
    a_t ea;
    r_t er;
    w_t ew;
    b_t eb;
    @(negedge clk);
    if (rstn) begin
      if (s_if.ar_valid && s_if.ar_ready) begin
        if (exp_ar.size() == 0) flag("slave_ar_unexpected");
        else begin
          ea = exp_ar.pop_front();
          check("slave_ar", {s_if.ar_addr, s_if.ar_len, s_if.ar_id}, ea);
        end
      end
      if (m0_if.r_valid && m0_if.r_ready) begin
        if (exp_r0.size() == 0) flag("m0_r_unexpected");
        else begin
          er = exp_r0.pop_front();
          check("m0_r", {m0_if.r_id, m0_if.r_data, m0_if.r_last}, er);
        end
      end
      if (m1_if.r_valid && m1_if.r_ready) begin
        if (exp_r1.size() == 0) flag("m1_r_unexpected");
        else begin
          er = exp_r1.pop_front();
          check("m1_r", {m1_if.r_id, m1_if.r_data, m1_if.r_last}, er);
        end
      end
      if (s_if.aw_valid && s_if.aw_ready) begin
        aw_cnt++;
        aw_hs_cyc = cyc;
        if (exp_aw.size() == 0) flag("slave_aw_unexpected");
        else begin
          ea = exp_aw.pop_front();
          check("slave_aw", {s_if.aw_addr, s_if.aw_len, s_if.aw_id}, ea);
        end
      end
      if (s_if.w_valid && s_if.w_ready) begin
        if (s_if.w_last) w_last_cyc = cyc;
        if (exp_w.size() == 0) flag("slave_w_unexpected");
        else begin
          ew = exp_w.pop_front();
          check("slave_w", {s_if.w_data, s_if.w_last}, ew);
        end
      end
      if (m0_if.b_valid && m0_if.b_ready) begin
        if (exp_b0.size() == 0) flag("m0_b_unexpected");
        else begin
          eb = exp_b0.pop_front();
          check("m0_b", {m0_if.b_id, m0_if.b_resp}, eb);
        end
      end
      if (m1_if.b_valid && m1_if.b_ready) begin
        if (exp_b1.size() == 0) flag("m1_b_unexpected");
        else begin
          eb = exp_b1.pop_front();
          check("m1_b", {m1_if.b_id, m1_if.b_resp}, eb);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200us");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n0;
    // Reset state: everything this block drives must be 0 even with inputs active.
    clear_masters();
    for (int m = 0; m < 2; m++) begin
      m_ar_valid[m] = 1'b1; m_aw_valid[m] = 1'b1; m_w_valid[m] = 1'b1;
    end
    s_ar_ready = 1'b1; s_r_valid = 1'b1; s_r_last = 1'b1; s_r_data = '0; s_r_id = '0;
    s_aw_ready = 1'b1; s_w_ready = 1'b1; s_b_valid = 1'b1; s_b_id = '0;
    #2;
    check("reset_outs", 64'(drv_outs()), 64'd0);
    do_reset();

    // 1: single read, one cycle of arbitration before AR reaches the slave.
    push_read(0, 32'h100, 8'd3, 4'h1);
    fork
      issue_ar(0, 32'h100, 8'd3, 4'h1);
      begin
        @(negedge clk);
        check("t1_ar_arb_cycle", 64'(s_if.ar_valid), 64'd0);
        @(negedge clk);
        check("t1_ar_forwarded", 64'(s_if.ar_valid), 64'd1);
      end
    join
    wait_drain("t1_drain");

    // 2: simultaneous requests after reset; master0 re-requests immediately.
    do_reset();
    push_read(0, 32'h500, 8'd0, 4'h1);
    push_read(1, 32'h600, 8'd0, 4'h2);
    push_read(0, 32'h510, 8'd0, 4'h3);
    fork
      begin
        issue_ar(0, 32'h500, 8'd0, 4'h1);
        for (int i = 0; i < 100; i++) begin
          @(posedge clk);
          if (exp_r0.size() == 2) break;
        end
        #1;
        issue_ar(0, 32'h510, 8'd0, 4'h3);
      end
      issue_ar(1, 32'h600, 8'd0, 4'h2);
    join
    wait_drain("t2_drain");

    // 3: W beats pass while the slave stalls AW for 5 cycles.
    aw_hold_cfg = 5;
    push_write(1, 32'h2000, 8'd1, 4'h7, 32'hB000);
    issue_wr(1, 32'h2000, 8'd1, 4'h7, 32'hB000);
    wait_drain("t3_drain");
    check("t3_w_before_aw", 64'(w_last_cyc < aw_hs_cyc), 64'd1);

    // 4: AW and last W complete together; B ready follows the master.
    aw_hold_cfg = 0;
    m_b_ready[0] = 1'b0;
    n0 = aw_cnt;
    push_write(0, 32'h3000, 8'd0, 4'h3, 32'hC000);
    fork
      issue_wr(0, 32'h3000, 8'd0, 4'h3, 32'hC000);
      begin
        for (int i = 0; i < 50; i++) begin
          @(posedge clk);
          if (aw_cnt != n0) break;
        end
        #1;
        check("t4_same_cycle", 64'(aw_hs_cyc), 64'(w_last_cyc));
        check("t4_bready_low", 64'(s_if.b_ready), 64'd0);
        m_b_ready[0] = 1'b1;
        #1;
        check("t4_bready_high", 64'(s_if.b_ready), 64'd1);
      end
    join
    wait_drain("t4_drain");

    // 5: master0 write and master1 read concurrently.
    push_write(0, 32'h4000, 8'd2, 4'h5, 32'hD000);
    push_read(1, 32'h5000, 8'd1, 4'h9);
    fork
      issue_wr(0, 32'h4000, 8'd2, 4'h5, 32'hD000);
      issue_ar(1, 32'h5000, 8'd1, 4'h9);
    join
    wait_drain("t5_drain");

    // 6: reset mid-burst; the round-robin pointer must return to master0-first.
    push_read(0, 32'h6000, 8'd0, 4'h2);
    issue_ar(0, 32'h6000, 8'd0, 4'h2);
    wait_drain("t6_pre_drain");
    push_read(0, 32'h7000, 8'd7, 4'h6);
    issue_ar(0, 32'h7000, 8'd7, 4'h6);
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      if (exp_r0.size() <= 5) break;
    end
    #3;
    rstn = 1'b0;
    #1;
    check("t6_reset_outs", 64'(drv_outs()), 64'd0);
    clear_queues();
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    push_read(0, 32'h8000, 8'd0, 4'h1);
    push_read(1, 32'h9000, 8'd0, 4'h2);
    fork
      issue_ar(0, 32'h8000, 8'd0, 4'h1);
      issue_ar(1, 32'h9000, 8'd0, 4'h2);
    join
    wait_drain("t6_drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
